// File: rtl/alu_res_buffer.sv
// alu_res_buffer: registered two-entry skid buffer between the ALU result
// sources and writeback. Drops x0-targeted results, tags each entry with a
// zero flag and counts writeback stall cycles (saturating).
module alu_res_buffer #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_res,
   input  logic [REG_W-1:0]  in_rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_res,
   output logic [REG_W-1:0]  out_rd,
   output logic              out_zero,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   m_res_q, m_res_d;
   logic [REG_W-1:0]    m_rd_q, m_rd_d;
   logic                m_zero_q, m_zero_d;
   logic [DATA_W-1:0]   s_res_q, s_res_d;
   logic [REG_W-1:0]    s_rd_q, s_rd_d;
   logic                s_zero_q, s_zero_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
   logic                acc;
   logic                pop;
   logic                in_zero;

   // Next-state, entry movement, handshake flags and stall counter
   always_comb begin
      state_d     = state_q;
      m_res_d     = m_res_q;
      m_rd_d      = m_rd_q;
      m_zero_d    = m_zero_q;
      s_res_d     = s_res_q;
      s_rd_d      = s_rd_q;
      s_zero_d    = s_zero_q;
      stall_cnt_d = stall_cnt_q;

      // x0 beats are handshaken but never enqueued
      acc     = in_valid && in_ready_q && (in_rd != '0);
      pop     = out_valid_q && out_ready;
      in_zero = (in_res == '0);

      case (state_q)
         ST_EMPTY: begin
            if (acc) begin
               m_res_d  = in_res;
               m_rd_d   = in_rd;
               m_zero_d = in_zero;
               state_d  = ST_ONE;
            end
         end
         ST_ONE: begin
            if (acc && pop) begin
               m_res_d  = in_res;
               m_rd_d   = in_rd;
               m_zero_d = in_zero;
            end else if (acc) begin
               s_res_d  = in_res;
               s_rd_d   = in_rd;
               s_zero_d = in_zero;
               state_d  = ST_FULL;
            end else if (pop) begin
               state_d  = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (pop) begin
               m_res_d  = s_res_q;
               m_rd_d   = s_rd_q;
               m_zero_d = s_zero_q;
               state_d  = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase

      in_ready_d  = (state_d != ST_FULL);
      out_valid_d = (state_d != ST_EMPTY);

      if (out_valid_q && !out_ready && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         m_res_q     <= '0;
         m_rd_q      <= '0;
         m_zero_q    <= 1'b0;
         s_res_q     <= '0;
         s_rd_q      <= '0;
         s_zero_q    <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         m_res_q     <= m_res_d;
         m_rd_q      <= m_rd_d;
         m_zero_q    <= m_zero_d;
         s_res_q     <= s_res_d;
         s_rd_q      <= s_rd_d;
         s_zero_q    <= s_zero_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_res   = m_res_q;
   assign out_rd    = m_rd_q;
   assign out_zero  = m_zero_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_alu_res_buffer.sv
// Directed self-checking bench for alu_res_buffer (stall counter narrowed to 4 bits).
module tb_alu_res_buffer;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned CNT_W  = 4;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_res;
   logic [REG_W-1:0]  in_rd;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_res;
   logic [REG_W-1:0]  out_rd;
   logic              out_zero;
   logic [CNT_W-1:0]  stall_cnt;

   int n_checks = 0;
   int n_fails  = 0;

   alu_res_buffer #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_res    (in_res),
      .in_rd     (in_rd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_rd    (out_rd),
      .out_zero  (out_zero),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd);
      in_valid = v;
      in_res   = res;
      in_rd    = rd;
   endtask

   logic [31:0] stream_res [4];
   logic        stream_zero [4];
   logic [31:0] a, b;
   int          exp_cnt;

   initial begin
      stream_res[0] = 32'hFFFF_FFFF; stream_zero[0] = 1'b0;
      stream_res[1] = 32'h0000_0000; stream_zero[1] = 1'b1;
      stream_res[2] = 32'hA5A5_A5A5; stream_zero[2] = 1'b0;
      stream_res[3] = 32'h5A5A_5A5A; stream_zero[3] = 1'b0;

      rst = 1'b1;
      out_ready = 1'b1;
      drive(1'b0, 32'h0, 5'd0);
      step();
      step();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_res", out_res, 32'h0);
      chk("rst_out_rd", 32'(out_rd), 32'd0);
      chk("rst_out_zero", 32'(out_zero), 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      rst = 1'b0;
      step();

      // single beat: A5A5A5A5 & 5A5A5A5A = 0
      a = 32'hA5A5_A5A5;
      b = 32'h5A5A_5A5A;
      drive(1'b1, a & b, 5'd3);
      step();
      drive(1'b0, 32'h0, 5'd0);
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_res", out_res, 32'h0);
      chk("single_rd", 32'(out_rd), 32'd3);
      chk("single_zero", 32'(out_zero), 32'd1);
      step();
      chk("single_drain", 32'(out_valid), 32'd0);

      // streaming at full rate
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, stream_res[i], 5'(i + 1));
         step();
         chk("stream_in_ready", 32'(in_ready), 32'd1);
         chk("stream_valid", 32'(out_valid), 32'd1);
         chk("stream_res", out_res, stream_res[i]);
         chk("stream_rd", 32'(out_rd), 32'(i + 1));
         chk("stream_zero", 32'(out_zero), 32'(stream_zero[i]));
      end
      drive(1'b0, 32'h0, 5'd0);
      step();
      chk("stream_drain", 32'(out_valid), 32'd0);
      chk("stream_no_stall", 32'(stall_cnt), 32'd0);

      // backpressure fills both entries
      out_ready = 1'b0;
      drive(1'b1, 32'd1, 5'd5);
      step();
      chk("bp_one_valid", 32'(out_valid), 32'd1);
      chk("bp_one_ready", 32'(in_ready), 32'd1);
      drive(1'b1, 32'd2, 5'd6);
      step();
      chk("bp_full_ready", 32'(in_ready), 32'd0);
      chk("bp_full_res", out_res, 32'd1);
      chk("bp_full_rd", 32'(out_rd), 32'd5);
      chk("bp_cnt1", 32'(stall_cnt), 32'd1);
      drive(1'b1, 32'd3, 5'd9);
      step();
      chk("bp_held_ready", 32'(in_ready), 32'd0);
      chk("bp_held_res", out_res, 32'd1);
      step();
      chk("bp_cnt3", 32'(stall_cnt), 32'd3);
      drive(1'b0, 32'h0, 5'd0);
      out_ready = 1'b1;
      step();
      chk("bp_second_valid", 32'(out_valid), 32'd1);
      chk("bp_second_res", out_res, 32'd2);
      chk("bp_second_rd", 32'(out_rd), 32'd6);
      chk("bp_after_ready", 32'(in_ready), 32'd1);
      chk("bp_cnt_hold", 32'(stall_cnt), 32'd3);
      step();
      chk("bp_drain", 32'(out_valid), 32'd0);
      chk("bp_no_third", 32'(out_rd), 32'd6);

      // x0 discard between two real beats
      drive(1'b1, 32'd1, 5'd7);
      step();
      chk("x0_first_rd", 32'(out_rd), 32'd7);
      chk("x0_first_res", out_res, 32'd1);
      drive(1'b1, 32'hDEAD_BEEF, 5'd0);
      step();
      chk("x0_dropped_valid", 32'(out_valid), 32'd0);
      chk("x0_dropped_res", out_res, 32'd1);
      chk("x0_ready", 32'(in_ready), 32'd1);
      drive(1'b1, 32'd2, 5'd8);
      step();
      chk("x0_second_rd", 32'(out_rd), 32'd8);
      chk("x0_second_res", out_res, 32'd2);
      chk("x0_second_zero", 32'(out_zero), 32'd0);
      drive(1'b0, 32'h0, 5'd0);
      step();
      chk("x0_drain", 32'(out_valid), 32'd0);
      chk("x0_cnt", 32'(stall_cnt), 32'd3);

      // stall counter saturation at 15
      out_ready = 1'b0;
      drive(1'b1, 32'h0, 5'd10);
      step();
      drive(1'b0, 32'h0, 5'd0);
      chk("sat_start", 32'(stall_cnt), 32'd3);
      exp_cnt = 3;
      for (int k = 0; k < 20; k++) begin
         step();
         if (exp_cnt < 15) exp_cnt++;
         chk("sat_cnt", 32'(stall_cnt), 32'(exp_cnt));
      end
      chk("sat_final", 32'(stall_cnt), 32'd15);

      // async reset while FULL
      drive(1'b1, 32'd5, 5'd11);
      step();
      drive(1'b0, 32'h0, 5'd0);
      chk("ar_full", 32'(in_ready), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_out_valid", 32'(out_valid), 32'd0);
      chk("ar_in_ready", 32'(in_ready), 32'd1);
      chk("ar_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("ar_out_res", out_res, 32'h0);
      chk("ar_out_rd", 32'(out_rd), 32'd0);
      chk("ar_out_zero", 32'(out_zero), 32'd0);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("ar_no_stale", 32'(out_valid), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/alu_res_buffer.md
Name: alu_res_buffer

Overview:
- Registered output stage directly downstream of the bitwise ALU (bit_operator) and the other ALU result sources, feeding writeback.
- Captures each ALU result with its destination register index and computes a registered zero flag.
- A two-entry skid buffer lets the ALU run at full throughput while writeback applies backpressure.
- Discards results targeting x0 and counts writeback stall cycles.

Parameters:
- DATA_W, 32, width of the ALU result.
- REG_W, 5, width of the destination register index.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  ALU result beat valid.
- in_ready  out  1  buffer can accept a beat this cycle.
- in_res  in  DATA_W  ALU result, e.g. the bit_operator res.
- in_rd  in  REG_W  destination register index.
- out_valid  out  1  head entry valid toward writeback.
- out_ready  in  1  writeback accepts the head entry.
- out_res  out  DATA_W  head result.
- out_rd  out  REG_W  head destination index.
- out_zero  out  1  head result equals 0.
- stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Handshakes:
  - Input beat accepted when in_valid && in_ready.
  - Output beat consumed when out_valid && out_ready.
- Storage:
  - Main register M drives all out_* ports.
  - Skid register S holds one overflow beat.
- States:
  - EMPTY: M and S invalid.
  - ONE: M valid, S invalid.
  - FULL: M and S valid.
- in_ready is registered: 1 in EMPTY or ONE, 0 in FULL. It is never combinationally dependent on out_ready.
- out_valid is 1 in ONE and FULL; all out_* ports are registered outputs.
- Latency: an accepted beat appears on out_* on the next clock edge when it enters M. Sustained throughput is 1 beat/cycle when out_ready=1.
- x0 discard:
  - An accepted beat with in_rd==0 is consumed (in_ready is honoured) but never enqueued.
  - State and stall_cnt are unaffected by it.
- Transitions (acc = accepted beat with in_rd!=0; pop = output consumed):
  - EMPTY: acc -> ONE, with M loaded.
  - ONE, acc and pop: stay ONE; M reloaded with the new beat.
  - ONE, acc and no pop: -> FULL; beat goes to S.
  - ONE, pop and no acc: -> EMPTY.
  - FULL, pop: -> ONE; S moves to M. No acceptance is possible in FULL because in_ready=0.
- Ordering: strict FIFO order; a beat in S always leaves after the beat in M.
- out_zero: computed when a beat is written into M or S as (res == 0), stored alongside it, and moved with the entry. Meaningful only when out_valid=1.
- stall_cnt: increments each cycle out_valid && !out_ready, and saturates at all-ones without wrapping.
- Reset (asynchronous, any time, including mid-transfer):
  - State -> EMPTY.
  - in_ready=1, out_valid=0.
  - out_res=0, out_rd=0, out_zero=0, stall_cnt=0.
  - Contents of S and M are discarded; no beat is emitted after reset release unless it is newly accepted.
- out_* values while out_valid=0 hold their last content; consumers must ignore them.

Test Plan:
- Reset then a single beat: in_res=A5A5A5A5 AND 5A5A5A5A result 00000000, in_rd=3, out_ready=1 -> next cycle out_valid=1, out_res=00000000, out_rd=3, out_zero=1; the following cycle out_valid=0.
- Streaming: 4 back-to-back beats with res FFFFFFFF, 00000000, A5A5A5A5, 5A5A5A5A, rd=1..4, out_ready=1 -> in_ready stays 1; outputs in order on consecutive cycles; out_zero pattern 0,1,0,0.
- Backpressure: out_ready=0, send rd=5 res=1 then rd=6 res=2 -> state FULL, in_ready=0 on the cycle after the second acceptance; a third in_valid is held off. Raise out_ready -> res 1 then 2 delivered; stall_cnt equals the cycles stalled, e.g. 3.
- x0 discard: beat rd=0 res=DEADBEEF between rd=7 res=1 and rd=8 res=2 -> only rd 7 and 8 appear; DEADBEEF never on out_res.
- Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15.
- Async reset mid-FULL: assert rst between clock edges -> out_valid=0, in_ready=1, stall_cnt=0 immediately; no stale beat after release.
